// File: rtl/fp_mul_err_monitor.sv
// Consumes (exact, approx) FP32 pairs and accumulates ULP error statistics over a programmed run.
// Latency: stats update 2 cycles after a transfer. Backpressure: registered in_ready, low outside RUN or once target reached.
module fp_mul_err_monitor #(
    parameter int CNT_W = 32,
    parameter int SUM_W = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic [31:0]      ulp_thresh,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      exact,
    input  logic [31:0]      approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] exceed_cnt,
    output logic [CNT_W-1:0] nan_cnt,
    output logic [31:0]      max_ulp,
    output logic [SUM_W-1:0] sum_ulp
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d, target_q, target_d;
    logic [31:0]      thresh_q, thresh_d;
    logic             s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    logic             s1_nan_one_q, s1_nan_one_d, s1_nan_both_q, s1_nan_both_d;
    logic [31:0]      s1_dist_q, s1_dist_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d, mismatch_cnt_q, mismatch_cnt_d;
    logic [CNT_W-1:0] exceed_cnt_q, exceed_cnt_d, nan_cnt_q, nan_cnt_d;
    logic [31:0]      max_ulp_q, max_ulp_d;
    logic [SUM_W-1:0] sum_ulp_q, sum_ulp_d;
    logic [SUM_W:0]   sum_ext;
    logic [32:0]      key_e, key_a, diff;
    logic             xfer, nan_e, nan_a;

    // Sign-magnitude to two's-complement ordering, so adjacent encodings differ by one and +0 == -0.
    function automatic logic [32:0] ord_key(input logic [31:0] x);
        logic [32:0] mag;
        mag = {2'b00, x[30:0]};
        return x[31] ? (33'd0 - mag) : mag;
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (&x[30:23]) && (|x[22:0]);
    endfunction

    assign xfer = in_valid && in_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     if (acc_cnt_q == target_q) state_d = DRAIN;
                DRAIN:   if (!s1_vld_q && !s2_vld_q) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == RUN) || (state_q == DRAIN);
        done = (state_q == DONE);
    end

    always_comb begin
        acc_cnt_d  = acc_cnt_q;
        target_d   = target_q;
        thresh_d   = thresh_q;
        in_ready_d = in_ready_q;
        if (start) begin
            acc_cnt_d  = '0;
            target_d   = num_samples;
            thresh_d   = ulp_thresh;
            in_ready_d = (num_samples != '0);
        end else if (xfer) begin
            acc_cnt_d  = acc_cnt_q + 1'b1;
            in_ready_d = (acc_cnt_d < target_q);
        end
    end

    always_comb begin
        key_e          = ord_key(exact);
        key_a          = ord_key(approx);
        diff           = key_e - key_a;
        nan_e          = is_nan(exact);
        nan_a          = is_nan(approx);
        s1_vld_d       = xfer && !start;
        s2_vld_d       = s1_vld_q && !start;
        s1_dist_d      = diff[32] ? 32'(33'd0 - diff) : diff[31:0];
        s1_nan_one_d   = nan_e ^ nan_a;
        s1_nan_both_d  = nan_e & nan_a;
    end

    always_comb begin
        sample_cnt_d   = sample_cnt_q;
        mismatch_cnt_d = mismatch_cnt_q;
        exceed_cnt_d   = exceed_cnt_q;
        nan_cnt_d      = nan_cnt_q;
        max_ulp_d      = max_ulp_q;
        sum_ulp_d      = sum_ulp_q;
        sum_ext        = {1'b0, sum_ulp_q} + {{(SUM_W - 31){1'b0}}, s1_dist_q};
        if (start) begin
            sample_cnt_d   = '0;
            mismatch_cnt_d = '0;
            exceed_cnt_d   = '0;
            nan_cnt_d      = '0;
            max_ulp_d      = '0;
            sum_ulp_d      = '0;
        end else if (s1_vld_q) begin
            sample_cnt_d = sample_cnt_q + 1'b1;
            if (s1_nan_one_q) begin
                nan_cnt_d      = nan_cnt_q + 1'b1;
                mismatch_cnt_d = mismatch_cnt_q + 1'b1;
            end else if (!s1_nan_both_q) begin
                if (s1_dist_q != '0)       mismatch_cnt_d = mismatch_cnt_q + 1'b1;
                if (s1_dist_q > thresh_q)  exceed_cnt_d   = exceed_cnt_q + 1'b1;
                if (s1_dist_q > max_ulp_q) max_ulp_d      = s1_dist_q;
                sum_ulp_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q     <= 1'b0;
            acc_cnt_q      <= '0;
            target_q       <= '0;
            thresh_q       <= '0;
            s1_vld_q       <= 1'b0;
            s2_vld_q       <= 1'b0;
            s1_nan_one_q   <= 1'b0;
            s1_nan_both_q  <= 1'b0;
            s1_dist_q      <= '0;
            sample_cnt_q   <= '0;
            mismatch_cnt_q <= '0;
            exceed_cnt_q   <= '0;
            nan_cnt_q      <= '0;
            max_ulp_q      <= '0;
            sum_ulp_q      <= '0;
        end else begin
            in_ready_q     <= in_ready_d;
            acc_cnt_q      <= acc_cnt_d;
            target_q       <= target_d;
            thresh_q       <= thresh_d;
            s1_vld_q       <= s1_vld_d;
            s2_vld_q       <= s2_vld_d;
            s1_nan_one_q   <= s1_nan_one_d;
            s1_nan_both_q  <= s1_nan_both_d;
            s1_dist_q      <= s1_dist_d;
            sample_cnt_q   <= sample_cnt_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            exceed_cnt_q   <= exceed_cnt_d;
            nan_cnt_q      <= nan_cnt_d;
            max_ulp_q      <= max_ulp_d;
            sum_ulp_q      <= sum_ulp_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign sample_cnt   = sample_cnt_q;
    assign mismatch_cnt = mismatch_cnt_q;
    assign exceed_cnt   = exceed_cnt_q;
    assign nan_cnt      = nan_cnt_q;
    assign max_ulp      = max_ulp_q;
    assign sum_ulp      = sum_ulp_q;
endmodule

// File: doc/fp_mul_err_monitor.md
Name: fp_mul_err_monitor

Overview:
- Streaming consumer for (exact, approx) FP32 product pairs from the exact and approximate multiplier datapaths.
- Compares each pair as an ordered-integer ULP distance and accumulates error statistics over a programmed number of samples.
- Acts as an on-chip stand-in for offline CSV post-processing, so approximation configurations can be characterised in hardware.

Parameters:
- CNT_W, 32, width of sample/event counters and num_samples.
- SUM_W, 48, width of saturating ULP-distance accumulator.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; clears stats, latches num_samples, begins run (accepted in any state).
- num_samples  input  CNT_W  number of pairs to consume in this run.
- ulp_thresh  input  32  exceed threshold, sampled at start.
- in_valid  input  1  pair valid.
- in_ready  output  1  monitor accepts pair; transfer when in_valid && in_ready.
- exact  input  32  FP32 reference result.
- approx  input  32  FP32 approximate result.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  high in DONE; stats final and stable.
- sample_cnt  output  CNT_W  pairs accepted and retired.
- mismatch_cnt  output  CNT_W  pairs with distance != 0, or NaN mismatch.
- exceed_cnt  output  CNT_W  non-NaN pairs with distance > ulp_thresh.
- nan_cnt  output  CNT_W  pairs where exactly one operand is NaN.
- max_ulp  output  32  maximum non-NaN distance.
- sum_ulp  output  SUM_W  saturating sum of non-NaN distances.

Behaviour:
- Reset: FSM IDLE; in_ready, busy and done = 0; all counters, max_ulp and sum_ulp = 0; pipeline valids = 0.
- FSM:
  - IDLE/DONE --start--> RUN.
  - RUN: in_ready=1 while accepted < target; when accepted == target (including target 0) --> DRAIN.
  - DRAIN: in_ready=0; --> DONE when both pipeline stages are empty.
  - DONE holds until start.
  - start in RUN/DRAIN restarts: clears stats and accepted count, kills in-flight stage valids, re-latches inputs, goes to RUN.
- in_ready is registered: it drops the cycle after the target-th acceptance. The accept counter must never exceed the target.
- Stage 1 (acceptance cycle +1), registered:
  - key(x) = sign ? -{1'b0,x[30:0]} : {1'b0,x[30:0]}, 32-bit signed.
  - dist = |key(exact) - key(approx)|, computed in 33 bits; always fits in 32 bits unsigned.
  - +0 and -0 give distance 0.
  - Inf is treated as an ordinary encoding.
  - NaN = exp 8'hFF && mant != 0. Compute nan_one (exactly one operand NaN) and nan_both.
- Stage 2 (acceptance +2): update stats registers.
  - sample_cnt always increments.
  - nan_both: no other update.
  - nan_one: nan_cnt++ and mismatch_cnt++.
  - Otherwise:
    - mismatch_cnt++ if dist != 0.
    - exceed_cnt++ if dist > thresh (strict).
    - max_ulp = max(max_ulp, dist).
    - sum_ulp += dist, saturating at all-ones.
- Stats become visible 2 cycles after a transfer. done asserts no earlier than the cycle after the final stage-2 update.
- in_valid is ignored when in_ready=0. Input data are don't-care then.
- Gaps in in_valid are allowed. No combinational path from in_valid to in_ready.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, in_ready=0, done=0.
- start, num_samples=3, thresh=0; pairs (3F800000,3F800000), (3F800000,3F800001), (3F800000,3F7FFFFF) -> sample 3, mismatch 2, exceed 2, max_ulp 1, sum_ulp 2, done=1, in_ready=0 after third transfer.
- Signed zeros: (00000000,80000000) -> dist 0, no mismatch; (00000001,80000001) -> max_ulp 2.
- NaN: (7FC00000,3F800000) -> nan_cnt 1, mismatch 1, max/sum unchanged; (7FC00000,7FC00001) -> counted sample only.
- thresh=4; distances 4 then 5 (3F800000 vs 3F800004, 3F800005) -> exceed_cnt 1, max_ulp 5, sum 9.
- Edge cases:
  - num_samples=0 -> reaches DONE with zero transfers.
  - Random in_valid gaps give the same stats as back-to-back input.
  - start mid-RUN after 2 transfers -> stats cleared and run restarts; prior in-flight sample not counted.
